mesh_phase_ctrl: RTL and testbench
==================================

Name: mesh_phase_ctrl

Overview:
- Global sequencer for the sqrt(N) x sqrt(N) PE mesh running shearsort.
- On a start pulse it does three things in order:
  - issues the PE memory-reload pulse;
  - steps the mesh through alternating row and column odd-even transposition phases;
  - runs a fixed-length compute window, then signals done.
- One instance drives the broadcast control inputs of every PE in the mesh.

Parameters:
- SQRT_N, 2: mesh side length; steps per sort phase. Must be ≥ 2.
- LOG_SQRT_N, 1: ceil(log2(SQRT_N)); the sort runs 2*LOG_SQRT_N+1 phases.
- SORT_CYCLES, 4: clock cycles per compare-exchange step. Must be ≥ 1.
- COMPUTE_CYCLES, 7: clock cycles in the post-sort compute window. Must be ≥ 1.
- PHASE_W, 2: width of o_phase_idx. Must satisfy 2^PHASE_W ≥ 2*LOG_SQRT_N+1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  run request; sampled only in IDLE.
- i_hold  in  1  stall; freezes state and all counters.
- o_rst_memory  out  1  one-cycle PE memory reload pulse.
- o_row_phase  out  1  high during row-sort phases.
- o_col_phase  out  1  high during column-sort phases.
- o_parity  out  1  odd/even exchange select for the current step.
- o_step_strobe  out  1  one-cycle pulse on the first cycle of each step.
- o_compute  out  1  high during the compute window.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_phase_idx  out  PHASE_W  index of the current sort phase, 0..2*LOG_SQRT_N.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-run): state = IDLE; all counters = 0; every output = 0.
- States: IDLE, LOAD, ROW, COL, COMPUTE, DONE.
- IDLE:
  - i_start=1 at edge t → next state LOAD.
  - At t+1: o_busy=1 and o_rst_memory=1, for exactly one cycle.
- LOAD → ROW with phase=0, step=0, cyc=0.
- ROW/COL:
  - cyc counts 0..SORT_CYCLES-1. At wrap, step increments 0..SQRT_N-1.
  - At step wrap, phase increments.
  - Even phase indices are ROW, odd ones are COL.
  - After phase 2*LOG_SQRT_N completes (always a ROW phase) → COMPUTE.
- Row/column flags: o_row_phase=1 in ROW only; o_col_phase=1 in COL only; never both.
- o_parity = step[0]. It is constant for the whole step.
- o_step_strobe = 1 exactly when cyc==0 and not held.
- o_phase_idx = phase during ROW/COL. Otherwise 0.
- COMPUTE: o_compute=1 for COMPUTE_CYCLES consecutive unheld cycles, then → DONE.
- DONE: o_done=1 for one cycle; o_busy=1 in that cycle; then → IDLE.
- i_hold=1:
  - The next state equals the current state; all counters hold.
  - All level outputs hold their values.
  - o_step_strobe and o_rst_memory are forced to 0 while held.
  - o_done is also forced to 0 while held; the DONE pulse and the LOAD pulse are deferred to the first unheld cycle in that state.
- i_hold in IDLE has no effect. i_start still has priority.
- i_start outside IDLE, including in DONE, is ignored. No queuing.
- Unheld run latency, from the start-sampling edge to the o_done cycle: 2 + (2*LOG_SQRT_N+1)*SQRT_N*SORT_CYCLES + COMPUTE_CYCLES.
  - At the defaults this is 33 cycles.
- Counter widths are sized by $clog2 of their terminal value + 1. There is no overflow path.

Test Plan:
1. Defaults. rst for 2 cycles, then a 1-cycle i_start.
   - LOAD pulse at cycle 1.
   - ROW cycles 2–9, COL cycles 10–17, ROW cycles 18–25. o_phase_idx = 0, 1, 2.
   - o_compute high cycles 26–32; o_done at cycle 33; o_busy high cycles 1–33.
2. Step strobes at defaults.
   - 6 strobes in total, at cycles 2, 6, 10, 14, 18, 22.
   - o_parity reads 0, 1, 0, 1, 0, 1 at those strobes.
3. i_hold=1 for 5 cycles starting at cycle 7.
   - All events from cycle 7 onward shift by 5; o_done arrives at cycle 38.
   - No strobe fires while held.
4. i_start pulsed at cycles 5 and 33 during a run.
   - Ignored; the run still completes at cycle 33.
   - A start at cycle 34 (IDLE) begins a new run with LOAD at cycle 35.
5. rst asserted asynchronously mid-COL (cycle 12).
   - All outputs go to 0 immediately; state is IDLE.
   - A subsequent start replays scenario 1 exactly.
6. SQRT_N=4, LOG_SQRT_N=2, SORT_CYCLES=1, COMPUTE_CYCLES=1, PHASE_W=3.
   - 5 phases × 4 steps; o_phase_idx takes values 0 through 4.
   - o_done arrives 2 + 20 + 1 = 23 cycles after start.

Source files
------------

// File: rtl/mesh_phase_ctrl.sv
// rtl/mesh_phase_ctrl.sv - global shearsort phase sequencer for the PE mesh
module mesh_phase_ctrl #(
    parameter int SQRT_N         = 2,
    parameter int LOG_SQRT_N     = 1,
    parameter int SORT_CYCLES    = 4,
    parameter int COMPUTE_CYCLES = 7,
    parameter int PHASE_W        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_hold,
    output logic               o_rst_memory,
    output logic               o_row_phase,
    output logic               o_col_phase,
    output logic               o_parity,
    output logic               o_step_strobe,
    output logic               o_compute,
    output logic               o_busy,
    output logic               o_done,
    output logic [PHASE_W-1:0] o_phase_idx
);

    localparam int STEP_W = $clog2(SQRT_N);
    localparam int CYC_W  = $clog2(SORT_CYCLES + 1);
    localparam int CMP_W  = $clog2(COMPUTE_CYCLES + 1);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * LOG_SQRT_N);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SQRT_N - 1);
    localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(SORT_CYCLES - 1);
    localparam logic [CMP_W-1:0]   CMP_LAST   = CMP_W'(COMPUTE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROW,
        S_COL,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t             state_q, state_n;
    logic [PHASE_W-1:0] phase_q, phase_n;
    logic [STEP_W-1:0]  step_q, step_n;
    logic [CYC_W-1:0]   cyc_q, cyc_n;
    logic [CMP_W-1:0]   cmp_q, cmp_n;
    logic               load_pend_q, load_pend_n;

    logic               rst_memory_n, done_n, sort_n;

    always_comb begin
        state_n      = state_q;
        phase_n      = phase_q;
        step_n       = step_q;
        cyc_n        = cyc_q;
        cmp_n        = cmp_q;
        load_pend_n  = load_pend_q;
        rst_memory_n = 1'b0;
        done_n       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_n      = S_LOAD;
                    // a start taken under hold enters LOAD but owes the reload pulse
                    rst_memory_n = !i_hold;
                    load_pend_n  = i_hold;
                end
            end
            S_LOAD: begin
                if (!i_hold) begin
                    if (load_pend_q) begin
                        load_pend_n  = 1'b0;
                        rst_memory_n = 1'b1;
                    end else begin
                        state_n = S_ROW;
                        phase_n = '0;
                        step_n  = '0;
                        cyc_n   = '0;
                    end
                end
            end
            S_ROW, S_COL: begin
                if (!i_hold) begin
                    if (cyc_q != CYC_LAST) begin
                        cyc_n = cyc_q + CYC_W'(1);
                    end else begin
                        cyc_n = '0;
                        if (step_q != STEP_LAST) begin
                            step_n = step_q + STEP_W'(1);
                        end else begin
                            step_n = '0;
                            if (phase_q == PHASE_LAST) begin
                                state_n = S_COMPUTE;
                                phase_n = '0;
                                cmp_n   = '0;
                            end else begin
                                phase_n = phase_q + PHASE_W'(1);
                                state_n = phase_n[0] ? S_COL : S_ROW;
                            end
                        end
                    end
                end
            end
            S_COMPUTE: begin
                if (!i_hold) begin
                    if (cmp_q == CMP_LAST) begin
                        state_n = S_DONE;
                        cmp_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cmp_n = cmp_q + CMP_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!i_hold) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        sort_n = (state_n == S_ROW) || (state_n == S_COL);
    end

    // outputs are registered views of the next state, so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            step_q        <= '0;
            cyc_q         <= '0;
            cmp_q         <= '0;
            load_pend_q   <= 1'b0;
            o_rst_memory  <= 1'b0;
            o_row_phase   <= 1'b0;
            o_col_phase   <= 1'b0;
            o_parity      <= 1'b0;
            o_step_strobe <= 1'b0;
            o_compute     <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_phase_idx   <= '0;
        end else begin
            state_q       <= state_n;
            phase_q       <= phase_n;
            step_q        <= step_n;
            cyc_q         <= cyc_n;
            cmp_q         <= cmp_n;
            load_pend_q   <= load_pend_n;
            o_rst_memory  <= rst_memory_n;
            o_row_phase   <= (state_n == S_ROW);
            o_col_phase   <= (state_n == S_COL);
            o_parity      <= sort_n & step_n[0];
            o_step_strobe <= sort_n & !i_hold & (cyc_n == '0);
            o_compute     <= (state_n == S_COMPUTE);
            o_busy        <= (state_n != S_IDLE);
            o_done        <= done_n;
            o_phase_idx   <= sort_n ? phase_n : '0;
        end
    end

endmodule

// File: tb/tb_mesh_phase_ctrl.sv
// tb/tb_mesh_phase_ctrl.sv - bench for mesh_phase_ctrl at default and 4x4 settings
module tb_mesh_phase_ctrl;

    logic clk, rst, start, hold;

    logic       rm0, rp0, cp0, pa0, ss0, cm0, bz0, dn0;
    logic [1:0] pi0;
    logic       rm1, rp1, cp1, pa1, ss1, cm1, bz1, dn1;
    logic [2:0] pi1;

    mesh_phase_ctrl dut0 (
        .clk(clk), .rst(rst), .i_start(start), .i_hold(hold),
        .o_rst_memory(rm0), .o_row_phase(rp0), .o_col_phase(cp0), .o_parity(pa0),
        .o_step_strobe(ss0), .o_compute(cm0), .o_busy(bz0), .o_done(dn0),
        .o_phase_idx(pi0)
    );

    mesh_phase_ctrl #(
        .SQRT_N(4), .LOG_SQRT_N(2), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .PHASE_W(3)
    ) dut1 (
        .clk(clk), .rst(rst), .i_start(start), .i_hold(hold),
        .o_rst_memory(rm1), .o_row_phase(rp1), .o_col_phase(cp1), .o_parity(pa1),
        .o_step_strobe(ss1), .o_compute(cm1), .o_busy(bz1), .o_done(dn1),
        .o_phase_idx(pi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: position along the nominal unheld timeline of a run
    int p_sqn[2] = '{2, 4};
    int p_sc[2]  = '{4, 1};
    int p_cc[2]  = '{7, 1};
    int p_np[2]  = '{3, 5};
    int m_run[2], m_pos[2], m_pend[2], m_held[2], m_rst[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_pend[i] = 0; m_held[i] = 0; m_rst[i] = 0;
        end
    endtask

    task automatic model_step(input logic s, input logic h);
        for (int i = 0; i < 2; i++) begin
            int len;
            len = 2 + p_np[i] * p_sqn[i] * p_sc[i] + p_cc[i];
            m_rst[i] = 0;
            if (m_run[i] == 0) begin
                if (s) begin
                    m_run[i] = 1; m_pos[i] = 1; m_pend[i] = h; m_rst[i] = !h;
                end
            end else if (!h) begin
                if (m_pos[i] == 1 && m_pend[i] != 0) begin
                    m_pend[i] = 0; m_rst[i] = 1;
                end else if (m_pos[i] == len) begin
                    m_run[i] = 0; m_pos[i] = 0;
                end else begin
                    m_pos[i]++;
                end
            end
            m_held[i] = h;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic [7:0] f;
            int pidx, sl, off, ph, st, cy, len;
            bit srt, cmp, dne;
            f    = (i == 0) ? {rm0, rp0, cp0, pa0, ss0, cm0, bz0, dn0}
                            : {rm1, rp1, cp1, pa1, ss1, cm1, bz1, dn1};
            pidx = (i == 0) ? int'(pi0) : int'(pi1);
            sl   = p_np[i] * p_sqn[i] * p_sc[i];
            len  = 2 + sl + p_cc[i];
            srt  = m_run[i] != 0 && m_pos[i] >= 2 && m_pos[i] < 2 + sl;
            off  = srt ? m_pos[i] - 2 : 0;
            ph   = off / (p_sqn[i] * p_sc[i]);
            st   = (off / p_sc[i]) % p_sqn[i];
            cy   = off % p_sc[i];
            cmp  = m_run[i] != 0 && m_pos[i] >= 2 + sl && m_pos[i] < len;
            dne  = m_run[i] != 0 && m_pos[i] == len && m_held[i] == 0;
            check_eq($sformatf("d%0d_rst_memory", i), f[7], m_rst[i]);
            check_eq($sformatf("d%0d_row_phase", i),  f[6], srt && ph % 2 == 0);
            check_eq($sformatf("d%0d_col_phase", i),  f[5], srt && ph % 2 == 1);
            check_eq($sformatf("d%0d_parity", i),     f[4], srt && st % 2 == 1);
            check_eq($sformatf("d%0d_step_strobe", i), f[3], srt && cy == 0 && m_held[i] == 0);
            check_eq($sformatf("d%0d_compute", i),    f[2], cmp);
            check_eq($sformatf("d%0d_busy", i),       f[1], m_run[i] != 0);
            check_eq($sformatf("d%0d_done", i),       f[0], dne);
            check_eq($sformatf("d%0d_phase_idx", i),  pidx, srt ? ph : 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_d0_outs"}, {rm0, rp0, cp0, pa0, ss0, cm0, bz0, dn0, pi0}, 0);
        check_eq({tag, "_d1_outs"}, {rm1, rp1, cp1, pa1, ss1, cm1, bz1, dn1, pi1}, 0);
    endtask

    task automatic run_cycle(input logic s, input logic h);
        start = s;
        hold  = h;
        @(posedge clk);
        model_step(s, h);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic flush();
        for (int c = 0; c < 80; c++) run_cycle(1'b0, 1'b0);
    endtask

    // plain run: done cycle and strobe totals for both instances
    task automatic run_basic(input string tag);
        int d0, d1, n0, n1;
        d0 = -1; d1 = -1; n0 = 0; n1 = 0;
        for (int c = 0; c < 45; c++) begin
            run_cycle(c == 0, 1'b0);
            if (dn0) d0 = c + 1;
            if (dn1) d1 = c + 1;
            if (ss0) n0++;
            if (ss1) n1++;
        end
        check_eq({tag, "_done_cycle_d0"}, d0, 33);
        check_eq({tag, "_done_cycle_d1"}, d1, 23);
        check_eq({tag, "_strobes_d0"}, n0, 6);
        check_eq({tag, "_strobes_d1"}, n1, 20);
        flush();
    endtask

    initial begin
        int d0, d1, l0, st0;
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_basic("basic");

        d0 = -1; d1 = -1; st0 = 0;
        for (int c = 0; c < 45; c++) begin
            run_cycle(c == 0, c >= 7 && c <= 11);
            if (dn0) d0 = c + 1;
            if (dn1) d1 = c + 1;
            if (ss0 && c >= 7 && c <= 11) st0++;
        end
        check_eq("hold_done_d0", d0, 38);
        check_eq("hold_done_d1", d1, 28);
        check_eq("hold_strobe_while_held", st0, 0);
        flush();

        d0 = -1; l0 = -1;
        for (int c = 0; c < 40; c++) begin
            run_cycle(c == 0 || c == 5 || c == 33 || c == 34, 1'b0);
            if (dn0 && d0 < 0) d0 = c + 1;
            if (rm0 && c > 0) l0 = c + 1;
        end
        check_eq("restart_done_d0", d0, 33);
        check_eq("restart_load_d0", l0, 35);
        flush();

        for (int c = 0; c < 12; c++) run_cycle(c == 0, 1'b0);
        check_eq("midcol_is_col", cp0, 1'b1);
        async_reset("midcol");
        run_basic("replay");

        for (int c = 0; c < 4000; c++) begin
            run_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
